vga_sync_gen: RTL and testbench

- Parametrised VGA timing generator; the next generation of the team's top-level VGA example.
- Produces hsync/vsync, an active-video flag and pixel coordinates for a downstream pixel/colour generator.
- Supports any resolution and sync polarity via parameters. A pixel-enable input allows a system clock faster than the pixel clock.
- Instantiated inside the tt_um_* wrapper; its outputs drive the uo_out VGA pin mapping.

---
 rtl/vga_sync_gen_if.sv | 33 +++
 rtl/vga_sync_gen.sv | 101 ++++++++++
 tb/tb_vga_sync_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: pixel-advance enable in, sync/position/flags out.
// frame_cnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
);
  logic             pix_en;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator with fully registered, mutually aligned outputs.
// Optional 8-bit frame counter enabled by VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  vga_sync_gen_if.master     vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
    $error("vga_sync_gen: illegal timing parameters");
  end

  logic [CNT_W-1:0] hpos_q, vpos_q, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             hsync_q, vsync_q, disp_q, ls_q, fs_q;

  // Next-state counters; all output flags are decoded from these so they
  // land in the same cycle as the position they describe.
  always_comb begin
    h_nxt  = hpos_q;
    v_nxt  = vpos_q;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (vga.pix_en) begin
      if (hpos_q == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        if (vpos_q == V_LAST) begin
          v_nxt  = '0;
          v_wrap = 1'b1;
        end else begin
          v_nxt  = vpos_q + 1'b1;
        end
      end else begin
        h_nxt = hpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      disp_q  <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hpos_q  <= h_nxt;
      vpos_q  <= v_nxt;
      hsync_q <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_q <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      disp_q  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      ls_q    <= h_wrap;
      fs_q    <= h_wrap && v_wrap;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = disp_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst)                 fcnt_q <= '0;
    else if (h_wrap && v_wrap) fcnt_q <= fcnt_q + 8'd1;
  end

  assign vga.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny 7x5 active-high
// timing with gated pix_en on a second instance.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CNT_W(10)) va ();
  vga_sync_gen_if #(.CNT_W(4))  vb ();

  vga_sync_gen u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (va)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (vb)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference position for the small instance, stepped on each enabled edge.
  int hx, vy;
  bit ls_e, fs_e;

  task automatic step_b(input bit en);
    vb.pix_en = en;
    tick();
    ls_e = 1'b0;
    fs_e = 1'b0;
    if (en) begin
      if (hx == 6) begin
        hx   = 0;
        ls_e = 1'b1;
        vy   = (vy == 4) ? 0 : vy + 1;
        fs_e = (vy == 0);
      end else begin
        hx = hx + 1;
      end
    end
    chk("b_hpos",  int'(vb.hpos), hx);
    chk("b_vpos",  int'(vb.vpos), vy);
    chk("b_hsync", int'(vb.hsync), int'(hx == 5));
    chk("b_vsync", int'(vb.vsync), int'(vy == 3));
    chk("b_disp",  int'(vb.display_on), int'(hx < 4 && vy < 2));
    chk("b_ls",    int'(vb.line_start), int'(ls_e));
    chk("b_fs",    int'(vb.frame_start), int'(fs_e));
  endtask

  initial begin
    int hs_lo, hs_first, hs_last, don_fall, ls_n, ls_h, ls_v, fs_n;

    rst_a = 1'b1;
    rst_b = 1'b1;
    va.pix_en = 1'b1;
    vb.pix_en = 1'b1;
    repeat (3) tick();

    // Reset state with pix_en held high: reset must win.
    chk("a_rst_hpos",  int'(va.hpos), 0);
    chk("a_rst_vpos",  int'(va.vpos), 0);
    chk("a_rst_hsync", int'(va.hsync), 1);
    chk("a_rst_vsync", int'(va.vsync), 1);
    chk("a_rst_disp",  int'(va.display_on), 1);
    chk("a_rst_ls",    int'(va.line_start), 0);
    chk("a_rst_fs",    int'(va.frame_start), 0);
    chk("b_rst_hsync", int'(vb.hsync), 0);
    chk("b_rst_vsync", int'(vb.vsync), 0);
    chk("b_rst_disp",  int'(vb.display_on), 1);
`ifdef VGA_FRAME_CNT_EN
    chk("a_rst_fcnt",  int'(va.frame_cnt), 0);
`endif

    // One full default line.
    rst_a = 1'b0;
    hs_lo = 0; hs_first = -1; hs_last = -1; don_fall = -1;
    ls_n = 0; ls_h = -1; ls_v = -1; fs_n = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (!va.hsync) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(va.hpos);
        hs_last = int'(va.hpos);
      end
      if (!va.display_on && don_fall < 0) don_fall = int'(va.hpos);
      if (va.line_start) begin
        ls_n++;
        ls_h = int'(va.hpos);
        ls_v = int'(va.vpos);
      end
      if (va.frame_start) fs_n++;
    end
    chk("a_hs_width", hs_lo, 96);
    chk("a_hs_first", hs_first, 656);
    chk("a_hs_last",  hs_last, 751);
    chk("a_disp_fall", don_fall, 640);
    chk("a_ls_count", ls_n, 1);
    chk("a_ls_hpos",  ls_h, 0);
    chk("a_ls_vpos",  ls_v, 1);
    chk("a_fs_count", fs_n, 0);
    chk("a_line_hpos", int'(va.hpos), 0);
    chk("a_line_vpos", int'(va.vpos), 1);
    chk("a_line_vsync", int'(va.vsync), 1);

    // pix_en low holds position, pulse drops.
    va.pix_en = 1'b0;
    repeat (2) tick();
    chk("a_hold_hpos", int'(va.hpos), 0);
    chk("a_hold_vpos", int'(va.vpos), 1);
    chk("a_hold_ls",   int'(va.line_start), 0);
    chk("a_hold_disp", int'(va.display_on), 1);
    va.pix_en = 1'b1;
    tick();
    chk("a_resume_hpos", int'(va.hpos), 1);

    // Small config, pix_en toggling, two full frames.
    rst_b = 1'b0;
    hx = 0;
    vy = 0;
    for (int i = 0; i < 140; i++) step_b(i[0] == 1'b0);

    // Walk into vsync (vpos 3, hpos 2), then reset mid-pulse.
    for (int i = 0; i < 40 && !(hx == 2 && vy == 3); i++) step_b(1'b1);
    chk("b_pre_rst_vsync", int'(vb.vsync), 1);
    rst_b = 1'b1;
    vb.pix_en = 1'b1;
    tick();
    chk("b_mid_rst_hpos",  int'(vb.hpos), 0);
    chk("b_mid_rst_vpos",  int'(vb.vpos), 0);
    chk("b_mid_rst_vsync", int'(vb.vsync), 0);
    chk("b_mid_rst_hsync", int'(vb.hsync), 0);
    chk("b_mid_rst_fs",    int'(vb.frame_start), 0);
    chk("b_mid_rst_ls",    int'(vb.line_start), 0);
    rst_b = 1'b0;
    hx = 0;
    vy = 0;
    for (int i = 0; i < 10; i++) step_b(1'b1);

`ifdef VGA_FRAME_CNT_EN
    // 256 frames of 35 pixels: counter wraps back to 0 on the last one.
    rst_b = 1'b1;
    tick();
    chk("b_fcnt_rst", int'(vb.frame_cnt), 0);
    rst_b = 1'b0;
    vb.pix_en = 1'b1;
    fs_n = 0;
    for (int i = 0; i < 35 * 256; i++) begin
      tick();
      if (vb.frame_start) begin
        fs_n++;
        chk("b_fcnt", int'(vb.frame_cnt), fs_n & 255);
      end
    end
    chk("b_fcnt_frames", fs_n, 256);
    chk("b_fcnt_wrap", int'(vb.frame_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
